mcp_controller_ws: RTL

- Parametrised successor to the multicycle MIPS controller; drives the multicycle datapath's control signals.
- Adds configurable memory wait states, with access strobes issued only on the final access cycle.
- Extends the ISA with addi, j and bne, and exposes the current FSM state for debug.
- Sits between the instruction register (op/funct) and the datapath; one instance per core.

---
 rtl/mcp_controller_ws_if.sv | 28 ++
 rtl/mcp_controller_ws.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mcp_controller_ws_if.sv
// mcp_controller_ws_if: instruction fields, ALU flag and datapath control lines between controller and datapath.
interface mcp_controller_ws_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
               alusrcb, pcsrc, alucontrol, state
    );
    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
               alusrcb, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/mcp_controller_ws.sv
// mcp_controller_ws: multicycle MIPS controller with configurable memory wait states.
module mcp_controller_ws #(
    parameter int MEM_LATENCY = 0,
    parameter int WCNT_W      = 4
) (
    input logic                 clk,
    input logic                 reset,
    mcp_controller_ws_if.master ctl
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEQEX = 4'd8, ADDIEX = 4'd9,
        ADDIWB = 4'd10, JEX = 4'd11, BNEEX = 4'd12
    } state_t;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
        OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d, wnext;
    logic              last;
    logic [2:0]        falu;
    assign last  = wcnt_q == WCNT_W'(MEM_LATENCY);
    assign wnext = last ? '0 : WCNT_W'(wcnt_q + 1'b1);
    assign ctl.state = state_q;
    assign falu = ctl.funct == 6'b100010 ? 3'b110 :
                  ctl.funct == 6'b100100 ? 3'b000 :
                  ctl.funct == 6'b100101 ? 3'b001 :
                  ctl.funct == 6'b101010 ? 3'b111 : 3'b010;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end
    always_comb begin
        state_d        = FETCH;
        wcnt_d         = '0;
        ctl.pcen       = 1'b0;
        ctl.memwrite   = 1'b0;
        ctl.irwrite    = 1'b0;
        ctl.regwrite   = 1'b0;
        ctl.alusrca    = 1'b0;
        ctl.iord       = 1'b0;
        ctl.memtoreg   = 1'b0;
        ctl.regdst     = 1'b0;
        ctl.alusrcb    = 2'b00;
        ctl.pcsrc      = 2'b00;
        ctl.alucontrol = 3'b010;
        case (state_q)
            FETCH: begin
                ctl.alusrcb = 2'b01;
                ctl.irwrite = last;
                ctl.pcen    = last;
                wcnt_d      = wnext;
                state_d     = last ? DECODE : FETCH;
            end
            DECODE: begin
                ctl.alusrcb = 2'b11;
                state_d = (ctl.op == OP_LW || ctl.op == OP_SW) ? MEMADR :
                          ctl.op == OP_R    ? RTYPEEX :
                          ctl.op == OP_BEQ  ? BEQEX :
                          ctl.op == OP_BNE  ? BNEEX :
                          ctl.op == OP_ADDI ? ADDIEX :
                          ctl.op == OP_J    ? JEX : FETCH;
            end
            MEMADR: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
                state_d     = ctl.op == OP_SW ? MEMWR : MEMRD;
            end
            MEMRD: begin
                ctl.iord = 1'b1;
                wcnt_d   = wnext;
                state_d  = last ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctl.regwrite = 1'b1;
                ctl.memtoreg = 1'b1;
            end
            MEMWR: begin
                ctl.iord     = 1'b1;
                ctl.memwrite = last;
                wcnt_d       = wnext;
                state_d      = last ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                ctl.alusrca    = 1'b1;
                ctl.alucontrol = falu;
                state_d        = RTYPEWB;
            end
            RTYPEWB: begin
                ctl.regwrite   = 1'b1;
                ctl.regdst     = 1'b1;
                ctl.alucontrol = falu;
            end
            BEQEX, BNEEX: begin
                ctl.alusrca    = 1'b1;
                ctl.alucontrol = 3'b110;
                ctl.pcsrc      = 2'b01;
                ctl.pcen       = (state_q == BEQEX) ? ctl.zero : ~ctl.zero;
            end
            ADDIEX: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
                state_d     = ADDIWB;
            end
            ADDIWB: ctl.regwrite = 1'b1;
            JEX: begin
                ctl.pcsrc = 2'b10;
                ctl.pcen  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        // strobes are suppressed while reset is held, even though the state already reads FETCH
        if (reset) begin
            ctl.pcen     = 1'b0;
            ctl.memwrite = 1'b0;
            ctl.irwrite  = 1'b0;
            ctl.regwrite = 1'b0;
        end
    end
endmodule
